// File: rtl/fixed_point_divider_arbiter_if.sv
// Request, response and divider-side bundle for fixed_point_divider_arbiter.
// The arbiter connects through "master"; requesters, consumer and divider connect through "slave".
interface fixed_point_divider_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_numerator;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_denominator;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [DATA_WIDTH-1:0] resp_quotient;
  logic                  resp_error;
  logic                  resp_timeout;

  logic                  div_in_valid;
  logic [DATA_WIDTH-1:0] div_in_numerator;
  logic [DATA_WIDTH-1:0] div_in_denominator;
  logic                  div_out_valid;
  logic [DATA_WIDTH-1:0] div_out_quotient;
  logic                  div_error_flag;

  modport master (
    input  req_valid, req_numerator, req_denominator, resp_ready,
           div_out_valid, div_out_quotient, div_error_flag,
    output req_ready, resp_valid, resp_id, resp_quotient, resp_error, resp_timeout,
           div_in_valid, div_in_numerator, div_in_denominator
  );

  modport slave (
    output req_valid, req_numerator, req_denominator, resp_ready,
           div_out_valid, div_out_quotient, div_error_flag,
    input  req_ready, resp_valid, resp_id, resp_quotient, resp_error, resp_timeout,
           div_in_valid, div_in_numerator, div_in_denominator
  );
endinterface

// File: rtl/fixed_point_divider_arbiter.sv
// Round-robin sequencer sharing one fixed-point divider among NUM_REQ requesters,
// one division in flight, with a timeout guard and an ID-tagged response.
//
// state | meaning
// IDLE  | pick next requester round-robin, accept and latch its operands
// ISSUE | single-cycle div_in_valid pulse with latched operands
// WAIT  | wait for div_out_valid or timeout expiry
// RESP  | hold response until resp_ready
module fixed_point_divider_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input logic                          clk,
  input logic                          rst,
  fixed_point_divider_arbiter_if.master bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       grant;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       cand;
  logic                  found;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] sel_num;
  logic [DATA_WIDTH-1:0] sel_den;

  // first valid requester after last_grant, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    sel_num = '0;
    sel_den = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_num = bus.req_numerator[i*DATA_WIDTH +: DATA_WIDTH];
        sel_den = bus.req_denominator[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == S_IDLE && found) bus.req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= S_IDLE;
      last_grant             <= ID_W'(NUM_REQ - 1);
      grant                  <= '0;
      wait_cnt               <= '0;
      bus.resp_valid         <= 1'b0;
      bus.resp_id            <= '0;
      bus.resp_quotient      <= '0;
      bus.resp_error         <= 1'b0;
      bus.resp_timeout       <= 1'b0;
      bus.div_in_valid       <= 1'b0;
      bus.div_in_numerator   <= '0;
      bus.div_in_denominator <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant                  <= winner;
            bus.div_in_numerator   <= sel_num;
            bus.div_in_denominator <= sel_den;
            bus.div_in_valid       <= 1'b1;
            state                  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.div_in_valid <= 1'b0;
          wait_cnt         <= '0;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // a result landing on the expiry cycle still beats the timeout
          if (bus.div_out_valid) begin
            bus.resp_quotient <= bus.div_out_quotient;
            bus.resp_error    <= bus.div_error_flag;
            bus.resp_timeout  <= 1'b0;
            bus.resp_id       <= grant;
            bus.resp_valid    <= 1'b1;
            state             <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            bus.resp_quotient <= '0;
            bus.resp_error    <= 1'b1;
            bus.resp_timeout  <= 1'b1;
            bus.resp_id       <= grant;
            bus.resp_valid    <= 1'b1;
            state             <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            last_grant     <= grant;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_divider_arbiter.sv
// Bench for fixed_point_divider_arbiter: behavioural Q12.20 divider, requester model,
// response scoreboard, vector table and directed multi-cycle sequences.
module tb_fixed_point_divider_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fixed_point_divider_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  fixed_point_divider_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    int           id;
    logic [DW-1:0] q;
    logic         err;
    logic         to;
    int           acc_cyc;
    int           lat;
  } exp_t;

  typedef struct {
    int           id;
    logic [DW-1:0] num;
    logic [DW-1:0] den;
    int           lat;
    logic [DW-1:0] q;
    logic         err;
    int           tol;
  } vec_t;

  exp_t sb[$];
  int   grant_log[$];
  exp_t last_resp;
  vec_t vecs[5];

  int vectors = 0, miscompares = 0;
  int cyc = 0, accepts = 0, resps = 0, div_pulses = 0;
  int lat_cfg = 3;
  bit suppress = 0, persist = 0, inject = 0, prev_rv = 0;
  bit div_busy = 0;
  int div_cnt = 0;
  logic [DW-1:0] div_q;
  logic          div_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name, input int info);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event/value %0d where none required (cycle %0d)", name, info, cyc);
  endtask

  // Q12.20 reference divide; divide by zero saturates and flags
  function automatic void ref_div(input logic [DW-1:0] n, input logic [DW-1:0] d,
                                  output logic [DW-1:0] q, output logic e);
    longint nn, dd;
    if (d == '0) begin
      q = 32'h7FFF_FFFF;
      e = 1'b1;
    end else begin
      nn = longint'($signed(n)) <<< 20;
      dd = longint'($signed(d));
      q  = DW'(nn / dd);
      e  = 1'b0;
    end
  endfunction

  task automatic drive_req(input int i, input logic [DW-1:0] n, input logic [DW-1:0] d);
    bus.req_numerator[i*DW +: DW]   = n;
    bus.req_denominator[i*DW +: DW] = d;
    bus.req_valid[i]                = 1'b1;
  endtask

  // one clock: observe at negedge, drive #1 after posedge
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    exp_t e;
    int id;
    @(negedge clk);
    cyc++;
    acc = '0;
    if (!rst) begin
      if (bus.div_in_valid) begin
        div_pulses++;
        ref_div(bus.div_in_numerator, bus.div_in_denominator, div_q, div_e);
        div_busy = 1;
        div_cnt  = lat_cfg - 1;
      end
      acc = bus.req_ready & bus.req_valid;
      if (bus.req_ready != '0) check("req_ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
      if (acc != '0) begin
        id = 0;
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) id = i;
        accepts++;
        grant_log.push_back(id);
        e.id      = id;
        e.acc_cyc = cyc;
        if (suppress) begin
          e.q = '0; e.err = 1'b1; e.to = 1'b1; e.lat = TIMEOUT + 2;
        end else begin
          ref_div(bus.req_numerator[id*DW +: DW], bus.req_denominator[id*DW +: DW], e.q, e.err);
          e.to  = 1'b0;
          e.lat = lat_cfg + 2;
        end
        sb.push_back(e);
      end
      if (bus.resp_valid && !prev_rv && sb.size() > 0)
        check("resp_latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          report_fail("unexpected_resp", int'(bus.resp_id));
        end else begin
          e = sb.pop_front();
          check("resp_id", 64'(bus.resp_id), 64'(e.id));
          check("resp_quotient", 64'(bus.resp_quotient), 64'(e.q));
          check("resp_error", 64'(bus.resp_error), 64'(e.err));
          check("resp_timeout", 64'(bus.resp_timeout), 64'(e.to));
          last_resp.id  = int'(bus.resp_id);
          last_resp.q   = bus.resp_quotient;
          last_resp.err = bus.resp_error;
          last_resp.to  = bus.resp_timeout;
          resps++;
        end
      end
    end
    prev_rv = bus.resp_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i] && !persist) bus.req_valid[i] = 1'b0;
    bus.div_out_valid = 1'b0;
    if (inject) begin
      bus.div_out_valid    = 1'b1;
      bus.div_out_quotient = 32'h1234_5678;
      bus.div_error_flag   = 1'b0;
      inject = 0;
    end else if (div_busy) begin
      if (div_cnt == 0) begin
        div_busy = 0;
        if (!suppress) begin
          bus.div_out_valid    = 1'b1;
          bus.div_out_quotient = div_q;
          bus.div_error_flag   = div_e;
        end
      end else begin
        div_cnt--;
      end
    end
  endtask

  task automatic run_until_resps(input int target, input int budget, input string name);
    int n = 0;
    while (resps < target && n < budget) begin
      step();
      n++;
    end
    if (resps < target) report_fail({name, "_timeout"}, resps);
  endtask

  initial begin
    int r0, n;
    longint d;
    vecs[0] = '{id: 1, num: 32'h0028_0000, den: 32'h0018_0000, lat: 3, q: 32'h001A_AAAA, err: 1'b0, tol: 10};
    vecs[1] = '{id: 2, num: 32'h0010_0000, den: 32'h0000_0000, lat: 1, q: 32'h7FFF_FFFF, err: 1'b1, tol: 0};
    vecs[2] = '{id: 0, num: 32'h0060_0000, den: 32'h0020_0000, lat: 4, q: 32'h0030_0000, err: 1'b0, tol: 0};
    vecs[3] = '{id: 3, num: 32'hFFD0_0000, den: 32'h0018_0000, lat: 2, q: 32'hFFE0_0000, err: 1'b0, tol: 0};
    vecs[4] = '{id: 1, num: 32'h0010_0000, den: 32'hFFC0_0000, lat: 6, q: 32'hFFFC_0000, err: 1'b0, tol: 0};

    rst = 1'b1;
    bus.req_valid = '0; bus.req_numerator = '0; bus.req_denominator = '0;
    bus.resp_ready = 1'b1;
    bus.div_out_valid = 1'b0; bus.div_out_quotient = '0; bus.div_error_flag = 1'b0;
    step();
    step();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_id", 64'(bus.resp_id), 64'd0);
    check("rst_resp_quotient", 64'(bus.resp_quotient), 64'd0);
    check("rst_resp_error", 64'(bus.resp_error), 64'd0);
    check("rst_resp_timeout", 64'(bus.resp_timeout), 64'd0);
    check("rst_div_in_valid", 64'(bus.div_in_valid), 64'd0);
    check("rst_div_in_num", 64'(bus.div_in_numerator), 64'd0);
    check("rst_div_in_den", 64'(bus.div_in_denominator), 64'd0);
    rst = 1'b0;
    step();

    // vector table: one requester at a time
    for (int v = 0; v < 5; v++) begin
      lat_cfg = vecs[v].lat;
      drive_req(vecs[v].id, vecs[v].num, vecs[v].den);
      run_until_resps(resps + 1, 40, "vec_resp");
      check("vec_id", 64'(last_resp.id), 64'(vecs[v].id));
      check("vec_error", 64'(last_resp.err), 64'(vecs[v].err));
      check("vec_timeout", 64'(last_resp.to), 64'd0);
      d = longint'($signed(last_resp.q)) - longint'($signed(vecs[v].q));
      if (d < 0) d = -d;
      check("vec_quotient_tol", 64'(d <= longint'(vecs[v].tol)), 64'd1);
      step();
    end

    // all four requesting continuously from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    persist = 1;
    lat_cfg = 1;
    for (int i = 0; i < NUM_REQ; i++) drive_req(i, DW'((i + 1) << 20), 32'h0020_0000);
    grant_log.delete();
    run_until_resps(resps + 5, 100, "rr_resp");
    persist = 0;
    bus.req_valid = '0;
    if (grant_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("rr_order", 64'(grant_log[k]), 64'(k % NUM_REQ));
    end else report_fail("rr_grant_count", grant_log.size());
    check("div_pulse_per_txn", 64'(div_pulses), 64'(accepts));

    // reset while in WAIT
    lat_cfg = 5;
    r0 = accepts;
    drive_req(3, 32'h0010_0000, 32'h0010_0000);
    n = 0;
    while (accepts == r0 && n < 20) begin step(); n++; end
    if (accepts == r0) report_fail("rstwait_accept_timeout", n);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    check("rstwait_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rstwait_div_in_valid", 64'(bus.div_in_valid), 64'd0);
    check("rstwait_div_in_num", 64'(bus.div_in_numerator), 64'd0);
    check("rstwait_div_in_den", 64'(bus.div_in_denominator), 64'd0);
    r0 = resps;
    for (int k = 0; k < 10; k++) step();
    check("rstwait_no_resp", 64'(resps), 64'(r0));
    drive_req(1, 32'h0020_0000, 32'h0010_0000);
    drive_req(0, 32'h0030_0000, 32'h0010_0000);
    grant_log.delete();
    run_until_resps(resps + 2, 60, "rstwait_resp");
    if (grant_log.size() >= 2) begin
      check("rstwait_first_grant", 64'(grant_log[0]), 64'd0);
      check("rstwait_second_grant", 64'(grant_log[1]), 64'd1);
    end else report_fail("rstwait_grant_count", grant_log.size());

    // timeout with suppressed divider, then a late stray result in IDLE
    suppress = 1;
    drive_req(2, 32'h0010_0000, 32'h0008_0000);
    run_until_resps(resps + 1, 40, "timeout_resp");
    check("timeout_quotient", 64'(last_resp.q), 64'd0);
    check("timeout_error", 64'(last_resp.err), 64'd1);
    check("timeout_flag", 64'(last_resp.to), 64'd1);
    suppress = 0;
    step();
    inject = 1;
    r0 = resps;
    for (int k = 0; k < 6; k++) begin
      step();
      check("late_result_resp_valid", 64'(bus.resp_valid), 64'd0);
    end
    check("late_result_no_resp", 64'(resps), 64'(r0));

    // backpressure: requester 1 stalled in RESP, then RR continues 2,3,0
    lat_cfg = 2;
    bus.resp_ready = 1'b0;
    drive_req(1, 32'h0050_0000, 32'h0020_0000);
    n = 0;
    while (!bus.resp_valid && n < 30) begin step(); n++; end
    if (!bus.resp_valid) report_fail("bp_resp_valid_timeout", n);
    drive_req(0, 32'h0010_0000, 32'h0010_0000);
    drive_req(2, 32'h0020_0000, 32'h0010_0000);
    drive_req(3, 32'h0030_0000, 32'h0010_0000);
    grant_log.delete();
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_resp_id", 64'(bus.resp_id), 64'd1);
      if (sb.size() > 0) check("bp_resp_quotient", 64'(bus.resp_quotient), 64'(sb[0].q));
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    run_until_resps(resps + 4, 80, "bp_resp");
    if (grant_log.size() >= 3) begin
      check("bp_grant_a", 64'(grant_log[0]), 64'd2);
      check("bp_grant_b", 64'(grant_log[1]), 64'd3);
      check("bp_grant_c", 64'(grant_log[2]), 64'd0);
    end else report_fail("bp_grant_count", grant_log.size());

    for (int k = 0; k < 3; k++) step();
    check("final_div_pulses", 64'(div_pulses), 64'(accepts));
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
